// File: rtl/nyq_pkg.sv
// Shared NYQ definitions: parameter-memory geometry and the loader state encoding.
// Used by both the parameter loader and the NYQ block itself.
package nyq_pkg;

  localparam int NYQ_ADDR_WIDTH = 5;
  localparam int NYQ_MEM_WIDTH  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } nyq_ld_state_e;

endpackage

// File: rtl/nyq_par_loader.sv
// NYQ parameter-memory write sequencer: bulk stream loads plus host single writes, one write/cycle, 1-cycle registered latency.
// Stream ready is low outside LOAD or during abort; single writes are granted only when IDLE and not starting a load.
module nyq_par_loader
  import nyq_pkg::*;
#(
  parameter int ADDR_WIDTH = NYQ_ADDR_WIDTH,
  parameter int MEM_WIDTH  = NYQ_MEM_WIDTH
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RI,
  input  logic                  Start_SI,
  input  logic [ADDR_WIDTH:0]   NumWords_DI,
  input  logic                  Abort_SI,
  input  logic                  StrmValid_SI,
  input  logic [MEM_WIDTH-1:0]  StrmData_DI,
  output logic                  StrmReady_SO,
  input  logic                  SglReq_SI,
  input  logic [ADDR_WIDTH-1:0] SglAddr_DI,
  input  logic [MEM_WIDTH-1:0]  SglData_DI,
  output logic                  SglGnt_SO,
  output logic                  WrEn_SO,
  output logic [ADDR_WIDTH-1:0] Addr_DO,
  output logic [MEM_WIDTH-1:0]  PAR_Out_DO,
  output logic                  Busy_SO,
  output logic                  Hold_SO,
  output logic                  Done_SO,
  output logic                  Aborted_SO
);

  localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH+1)'(1);

  nyq_ld_state_e r_state;
  nyq_ld_state_e w_state_nxt;

  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH:0]   r_num;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [MEM_WIDTH-1:0]  r_data;
  logic                  r_done;
  logic                  r_aborted;

  logic w_rdy;
  logic w_accept;
  logic w_last;
  logic w_gnt;
  logic w_start;

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rdy       = 1'b0;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    w_start     = 1'b0;
    w_gnt       = 1'b0;
    case (r_state)
      IDLE: begin
        w_start = Start_SI;
        w_gnt   = SglReq_SI & ~Start_SI;
        if (Start_SI && (NumWords_DI != '0)) w_state_nxt = LOAD;
      end
      LOAD: begin
        // Abort wins over a word presented in the same cycle.
        w_rdy    = ~Abort_SI;
        w_accept = StrmValid_SI & w_rdy;
        w_last   = ({1'b0, r_cnt} == (r_num - ONE));
        if (Abort_SI)                w_state_nxt = IDLE;
        else if (w_accept && w_last) w_state_nxt = FLUSH;
      end
      FLUSH:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      r_cnt     <= '0;
      r_num     <= '0;
      r_wr_en   <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_wr_en   <= w_accept | w_gnt;
      r_done    <= (w_start && (NumWords_DI == '0)) || (r_state == FLUSH);
      r_aborted <= (r_state == LOAD) && Abort_SI;
      if (w_start) begin
        r_cnt <= '0;
        r_num <= NumWords_DI;
      end
      if (w_accept) begin
        r_addr <= r_cnt;
        r_data <= StrmData_DI;
        // Holding on the last word keeps a full-depth load from wrapping to 0.
        if (!w_last) r_cnt <= r_cnt + 1'b1;
      end else if (w_gnt) begin
        r_addr <= SglAddr_DI;
        r_data <= SglData_DI;
      end
    end
  end

  assign StrmReady_SO = w_rdy;
  assign SglGnt_SO    = w_gnt;
  assign WrEn_SO      = r_wr_en;
  assign Addr_DO      = r_addr;
  assign PAR_Out_DO   = r_data;
  assign Busy_SO      = (r_state != IDLE);
  assign Hold_SO      = (r_state != IDLE);
  assign Done_SO      = r_done;
  assign Aborted_SO   = r_aborted;

endmodule

// File: tb/tb_nyq_par_loader.sv
// Directed bench for nyq_par_loader: bulk loads, bubbles, abort, arbitration and stray controls.
module tb_nyq_par_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  num = '0;
  logic        abort = 1'b0;
  logic        sv = 1'b0;
  logic [31:0] sd = '0;
  logic        srdy;
  logic        sreq = 1'b0;
  logic [4:0]  saddr = '0;
  logic [31:0] sdata = '0;
  logic        sgnt;
  logic        wren;
  logic [4:0]  addr;
  logic [31:0] pdat;
  logic        busy;
  logic        hold;
  logic        done;
  logic        aborted;

  int n_assert = 0;
  int n_fail   = 0;
  int hold_cnt = 0;
  int done_cnt = 0;
  int h0;
  int d0;

  always #5 clk = ~clk;

  nyq_par_loader dut (
    .Clk_CI(clk), .Rst_RI(rst), .Start_SI(start), .NumWords_DI(num), .Abort_SI(abort),
    .StrmValid_SI(sv), .StrmData_DI(sd), .StrmReady_SO(srdy),
    .SglReq_SI(sreq), .SglAddr_DI(saddr), .SglData_DI(sdata), .SglGnt_SO(sgnt),
    .WrEn_SO(wren), .Addr_DO(addr), .PAR_Out_DO(pdat), .Busy_SO(busy), .Hold_SO(hold),
    .Done_SO(done), .Aborted_SO(aborted)
  );

  always @(negedge clk) begin
    if (hold) hold_cnt++;
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_wren"}, 32'(wren), 32'd1);
    chk({tag, "_addr"}, 32'(addr), 32'(a));
    chk({tag, "_data"}, pdat, d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset
    tick(); tick();
    #1;
    chk("rst_wren", 32'(wren), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_data", pdat, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_hold", 32'(hold), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_abrt", 32'(aborted), 0);
    chk("rst_srdy", 32'(srdy), 0);
    chk("rst_sgnt", 32'(sgnt), 0);
    rst = 1'b0;
    tick();

    // Bulk load of 4 words, no bubbles
    h0 = hold_cnt; d0 = done_cnt;
    start = 1'b1; num = 6'd4;
    tick();
    start = 1'b0;
    chk("b4_busy_c1", 32'(busy), 1);
    chk("b4_srdy_c1", 32'(srdy), 1);
    chk("b4_wren_c1", 32'(wren), 0);
    for (int i = 0; i < 4; i++) begin
      sv = 1'b1; sd = 32'hA0 + 32'(i);
      tick();
      chk_wr("b4", 5'(i), 32'hA0 + 32'(i));
      chk("b4_done", 32'(done), 0);
    end
    sv = 1'b0;
    #1;
    chk("b4_flush_busy", 32'(busy), 1);
    chk("b4_flush_srdy", 32'(srdy), 0);
    tick();
    chk("b4_done_c6", 32'(done), 1);
    chk("b4_busy_c6", 32'(busy), 0);
    chk("b4_wren_c6", 32'(wren), 0);
    chk("b4_addr_hold", 32'(addr), 3);
    chk("b4_data_hold", pdat, 32'hA3);
    tick();
    chk("b4_done_c7", 32'(done), 0);
    chk("b4_hold_cycles", 32'(hold_cnt - h0), 5);
    chk("b4_done_pulses", 32'(done_cnt - d0), 1);

    // Full depth with a bubble after every word
    d0 = done_cnt;
    start = 1'b1; num = 6'd32;
    tick();
    start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      sv = 1'b1; sd = 32'hB000 + 32'(k);
      tick();
      chk_wr("full", 5'(k), 32'hB000 + 32'(k));
      if (k < 31) begin
        sv = 1'b0; sd = 32'hDEAD;
        tick();
        chk("full_gap_wren", 32'(wren), 0);
        chk("full_gap_addr", 32'(addr), 32'(k));
        chk("full_gap_busy", 32'(busy), 1);
      end
    end
    sv = 1'b0;
    tick();
    chk("full_done", 32'(done), 1);
    chk("full_nowrap", 32'(addr), 31);
    tick();
    chk("full_done_pulses", 32'(done_cnt - d0), 1);
    chk("full_idle", 32'(busy), 0);

    // Abort together with the third word
    d0 = done_cnt;
    start = 1'b1; num = 6'd8;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sv = 1'b1; sd = 32'hD0 + 32'(i);
      tick();
      chk_wr("abt", 5'(i), 32'hD0 + 32'(i));
    end
    sv = 1'b1; sd = 32'hD2; abort = 1'b1;
    #1;
    chk("abt_srdy", 32'(srdy), 0);
    tick();
    sv = 1'b0; abort = 1'b0;
    chk("abt_pulse", 32'(aborted), 1);
    chk("abt_wren", 32'(wren), 0);
    chk("abt_busy", 32'(busy), 0);
    chk("abt_addr", 32'(addr), 1);
    chk("abt_data", pdat, 32'hD1);
    tick();
    chk("abt_pulse_end", 32'(aborted), 0);
    chk("abt_no_done", 32'(done_cnt - d0), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abt_idle_ignored", 32'(aborted), 0);

    // Single request colliding with Start
    start = 1'b1; num = 6'd2;
    sreq = 1'b1; saddr = 5'd7; sdata = 32'h1234;
    #1;
    chk("arb_gnt_start", 32'(sgnt), 0);
    tick();
    start = 1'b0; sv = 1'b1; sd = 32'hC0;
    #1;
    chk("arb_gnt_load0", 32'(sgnt), 0);
    tick();
    chk_wr("arb_ld0", 5'd0, 32'hC0);
    sd = 32'hC1;
    #1;
    chk("arb_gnt_load1", 32'(sgnt), 0);
    tick();
    chk_wr("arb_ld1", 5'd1, 32'hC1);
    sv = 1'b0;
    #1;
    chk("arb_gnt_flush", 32'(sgnt), 0);
    tick();
    chk("arb_done", 32'(done), 1);
    chk("arb_gnt_idle", 32'(sgnt), 1);
    tick();
    sreq = 1'b0;
    chk_wr("arb_sgl", 5'd7, 32'h1234);
    tick();
    chk("arb_sgl_end", 32'(wren), 0);

    // Back-to-back single writes in IDLE
    sreq = 1'b1; saddr = 5'h1A; sdata = 32'h55AA;
    #1;
    chk("sgl_gnt", 32'(sgnt), 1);
    tick();
    chk_wr("sgl_a", 5'h1A, 32'h55AA);
    saddr = 5'h1B; sdata = 32'h6600;
    tick();
    chk_wr("sgl_b", 5'h1B, 32'h6600);
    sreq = 1'b0;
    tick();
    chk("sgl_end_wren", 32'(wren), 0);
    chk("sgl_end_addr", 32'(addr), 32'h1B);

    // Zero-length load
    start = 1'b1; num = 6'd0;
    tick();
    start = 1'b0;
    chk("zero_done", 32'(done), 1);
    chk("zero_busy", 32'(busy), 0);
    chk("zero_wren", 32'(wren), 0);
    tick();
    chk("zero_done_end", 32'(done), 0);

    // Start and Abort during FLUSH are ignored
    start = 1'b1; num = 6'd1;
    tick();
    start = 1'b0; sv = 1'b1; sd = 32'hE0;
    tick();
    chk_wr("fl", 5'd0, 32'hE0);
    sv = 1'b0; start = 1'b1; num = 6'd3; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("fl_done", 32'(done), 1);
    chk("fl_no_abort", 32'(aborted), 0);
    chk("fl_idle", 32'(busy), 0);
    tick();
    chk("fl_start_ignored", 32'(busy), 0);
    chk("fl_wren", 32'(wren), 0);

    // Reset in the middle of a load
    d0 = done_cnt;
    start = 1'b1; num = 6'd4;
    tick();
    start = 1'b0; sv = 1'b1; sd = 32'hF0;
    tick();
    sv = 1'b0; rst = 1'b1;
    tick();
    chk("mrst_wren", 32'(wren), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_addr", 32'(addr), 0);
    rst = 1'b0;
    tick(); tick();
    chk("mrst_no_done", 32'(done_cnt - d0), 0);
    chk("mrst_no_abort", 32'(aborted), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/nyq_par_loader.md
Name: nyq_par_loader

Overview:
- Sequences the NYQ parameter-memory write port: bulk loads of consecutive coefficient words from a valid/ready stream, plus single-word host writes.
- Drives the NYQ block's write enable, address and parameter data pins.
- Raises a hold flag during bulk loads so upstream logic freezes NYQ samples while coefficients are inconsistent.
- Sits between the config host/DMA and the NYQ block.

Parameters:
- ADDR_WIDTH, 5, parameter-memory address bits; depth = 2^ADDR_WIDTH.
- MEM_WIDTH, 32, parameter word width.

Ports:
- Clk_CI  in  1  clock; all logic on rising edge.
- Rst_RI  in  1  synchronous active-high reset.
- Start_SI  in  1  pulse: begin bulk load at address 0.
- NumWords_DI  in  ADDR_WIDTH+1  words in bulk load, 0..2^ADDR_WIDTH; sampled with Start_SI.
- Abort_SI  in  1  terminate bulk load.
- StrmValid_SI  in  1  stream word valid.
- StrmData_DI  in  MEM_WIDTH  stream word.
- StrmReady_SO  out  1  stream ready.
- SglReq_SI  in  1  single-write request; held until granted.
- SglAddr_DI  in  ADDR_WIDTH  single-write address.
- SglData_DI  in  MEM_WIDTH  single-write data.
- SglGnt_SO  out  1  single-write grant (combinational).
- WrEn_SO  out  1  to NYQ WrEn_SI.
- Addr_DO  out  ADDR_WIDTH  to NYQ Addr_DI.
- PAR_Out_DO  out  MEM_WIDTH  to NYQ PAR_In_DI.
- Busy_SO  out  1  high while not IDLE.
- Hold_SO  out  1  freeze NYQ samples.
- Done_SO  out  1  one-cycle pulse: bulk load completed.
- Aborted_SO  out  1  one-cycle pulse: bulk load aborted.

Behaviour:
- Reset: state IDLE; word counter 0; all outputs 0. Reset mid-load drops any pending write, with no Done or Aborted pulse.
- States: IDLE, LOAD, FLUSH.
- IDLE:
  - Start_SI with NumWords_DI=0 -> stay IDLE; Done_SO=1 next cycle.
  - Start_SI with NumWords_DI>0 -> LOAD; latch count; counter=0.
  - Start_SI ignored outside IDLE.
- LOAD:
  - StrmReady_SO = (state==LOAD) & !Abort_SI; it never depends on StrmValid_SI.
  - Accept = Valid & Ready. On an accept at edge k, cycle k+1 has WrEn_SO=1, Addr_DO=counter, PAR_Out_DO=word; then counter increments.
  - Last accept (counter==count-1) -> FLUSH.
  - Bubbles (Valid low) -> WrEn_SO=0 that cycle; state unchanged.
- FLUSH: carries the final registered write on WrEn_SO/Addr_DO/PAR_Out_DO. Next state IDLE, with Done_SO=1 in that first IDLE cycle.
- Full load of 32 words: addresses 0..31; the counter never wraps; the last write goes to 31.
- Abort_SI in LOAD: takes priority over a simultaneous stream word, which is not accepted. Next cycle: IDLE, Aborted_SO=1, WrEn_SO=0. Writes already issued remain. Abort_SI in IDLE or FLUSH is ignored.
- Busy_SO = Hold_SO = (state != IDLE), registered with the state.
- Single writes:
  - SglGnt_SO = SglReq_SI & (state==IDLE) & !Start_SI; Start has priority.
  - Granted at edge k -> cycle k+1 has WrEn_SO=1, Addr_DO=SglAddr_DI, PAR_Out_DO=SglData_DI.
  - Back-to-back grants allowed, one per cycle.
- When WrEn_SO=0, Addr_DO and PAR_Out_DO hold their last values.
- Throughput: one write per cycle. Bulk load of N words with no bubbles: Busy for N+1 cycles; Done pulses N+2 cycles after Start.

Decomposition:
- Shared package nyq_pkg: state enum (IDLE/LOAD/FLUSH), defaults NYQ_ADDR_WIDTH=5 and NYQ_MEM_WIDTH=32, shared with the NYQ block.
- No sub-module: a single FSM with a counter and an output register; the write mux is inline.

Test Plan:
- Reset then idle: Rst_RI=1 for 2 cycles -> all outputs 0; Busy_SO=0.
- Bulk load: Start with NumWords=4, stream 0xA0..0xA3 without bubbles -> writes at addresses 0..3 on consecutive cycles starting 1 cycle after the first accept; Done pulse 6 cycles after Start; Hold high for exactly 5 cycles.
- Bubbles and full depth: NumWords=32, StrmValid toggling 1/0 -> 32 writes at addresses 0..31 with WrEn gaps; no wrap; a single Done pulse.
- Abort: NumWords=8, assert Abort together with the 3rd word -> only addresses 0..1 written; 3rd word not accepted; Aborted_SO pulse; no Done; IDLE next cycle.
- Arbitration: SglReq (addr 7, data 0x1234) in the same cycle as Start -> no grant that cycle. Grant comes only after the load's Done; then WrEn with Addr 7, data 0x1234. A single request in IDLE -> grant, with the write the next cycle.
- NumWords=0 and stray controls: Start with NumWords=0 -> no write, Done next cycle. Start or Abort during FLUSH -> ignored.
